fc_argmax_comparator: RTL and testbench
=======================================

Name: fc_argmax_comparator

Overview:
Final classification stage of the MNIST CNN pipeline. Consumes the serial stream of signed class scores from the fully-connected layer (one score per valid cycle, class 0 first) and outputs the index of the maximum score as a 4-bit decision. Emits a one-cycle valid pulse per completed group of NUM_CLASSES scores.

Parameters:
DATA_BITS, 12, width of signed input score
NUM_CLASSES, 10, scores per classification group
IDX_BITS, 4, width of decision / class index (must satisfy 2**IDX_BITS >= NUM_CLASSES)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
valid_in  input  1  data_in holds a valid score this cycle
data_in  input  DATA_BITS  signed two's-complement class score
decision  output  IDX_BITS  index of the maximum score of the last completed group
valid_out  output  1  one-cycle pulse: decision updated this cycle

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n): sampled only on rising clk edge.
- Reset: decision=0, valid_out=0, class counter=0, running max and running index cleared. Reset mid-group discards partial scores; next valid_in after release is class 0.
- Class counter (IDX_BITS) increments on every cycle with valid_in=1; cycles with valid_in=0 are ignored (gaps allowed, no timeout).
- Counter==0 sample: unconditionally loads running max=data_in, running index=0.
- Counter>0 sample: signed compare; if data_in > running max (strict), load running max=data_in, running index=counter. Ties keep the earlier (lower) index.
- Sample with counter==NUM_CLASSES-1 (last of group): on that same edge, decision <= final argmax (including this sample's comparison), valid_out <= 1, counter <= 0. Latency: valid_out is high in the cycle after the last score is presented.
- valid_out is 1 for exactly one cycle, otherwise 0. Back-to-back groups supported: class 0 of the next group may arrive the cycle after the last score of the previous group, with no bubble.
- decision holds its value between pulses; it changes only on a valid_out pulse or reset.
- Comparisons are full-width signed; no saturation or truncation. All scores of a group equal -> decision=0.
- valid_in during reset is ignored.

Optional Feature:
Macro ARGMAX_MAX_VALUE_OUT_EN. Defined: adds output port max_value (DATA_BITS, signed), registered on the same edge as decision, holding the winning score; reset value 0. Undefined: port and its register absent; all other behaviour identical.

Decomposition:
- Shared package cnn_pkg: NUM_CLASSES=10, FC_DATA_BITS=12, CLASS_IDX_BITS=4, typedef for the signed score type and the class index type, reused by fully_connected and the bench.
- No sub-module; single flat block (counter + compare/update register bank).

Test Plan:
- Scores 5,-3,100,7,0,2,99,-50,1,3 contiguous -> one cycle after the 10th, valid_out=1 for one cycle, decision=2.
- All ten scores -2048 (most negative) -> decision=0; with ARGMAX_MAX_VALUE_OUT_EN, max_value=-2048.
- Scores with tie 40 at class 3 and class 8, others lower -> decision=3; max at class 9 only (2047) -> decision=9.
- Same group with valid_in deasserted 1-3 random cycles between scores -> decision identical to contiguous case; valid_out only after 10th valid score.
- Two back-to-back groups (argmax 2 then 7) without gap -> two pulses exactly 10 cycles apart, decision 2 then 7; decision holds 2 until the second pulse.
- Assert rst_n=0 for one cycle after 4 scores, then send full group argmax 6 -> no pulse from partial group; decision=0 during and after reset until pulse shows 6.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and sizes for the MNIST CNN datapath: class count, score width
// and class-index width used by the fully-connected layer, the argmax stage and the bench.
package cnn_pkg;

  localparam int NUM_CLASSES    = 10;
  localparam int FC_DATA_BITS   = 12;
  localparam int CLASS_IDX_BITS = 4;

  typedef logic signed [FC_DATA_BITS-1:0] score_t;
  typedef logic        [CLASS_IDX_BITS-1:0] class_idx_t;

endpackage

// File: rtl/fc_argmax_comparator.sv
// Final classifier stage: tracks the running maximum of each group of NUM_CLASSES serial
// scores and pulses valid_out with the winning index. `define ARGMAX_MAX_VALUE_OUT_EN adds max_value.
module fc_argmax_comparator
  import cnn_pkg::*;
#(
  parameter int DATA_BITS   = FC_DATA_BITS,
  parameter int NUM_CLASSES = cnn_pkg::NUM_CLASSES,
  parameter int IDX_BITS    = CLASS_IDX_BITS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic signed [DATA_BITS-1:0] data_in,
  output logic        [IDX_BITS-1:0]  decision,
  output logic                        valid_out
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  ,
  output logic signed [DATA_BITS-1:0] max_value
`endif
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

  logic        [IDX_BITS-1:0]  r_cnt;
  logic        [IDX_BITS-1:0]  r_idx;
  logic signed [DATA_BITS-1:0] r_max;
  logic        [IDX_BITS-1:0]  r_decision;
  logic                        r_valid;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  logic signed [DATA_BITS-1:0] r_max_value;
`endif

  logic                        w_first;
  logic                        w_last;
  logic                        w_take;
  logic signed [DATA_BITS-1:0] w_max_nxt;
  logic        [IDX_BITS-1:0]  w_idx_nxt;

  // Strict compare so ties keep the earlier (lower) class index.
  function automatic logic beats(input logic signed [DATA_BITS-1:0] cand,
                                 input logic signed [DATA_BITS-1:0] best);
    return cand > best;
  endfunction

  always_comb begin
    w_first   = (r_cnt == '0);
    w_last    = (r_cnt == LAST_IDX);
    w_take    = w_first || beats(data_in, r_max);
    w_max_nxt = w_take ? data_in : r_max;
    w_idx_nxt = w_take ? r_cnt : r_idx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_max      <= '0;
      r_decision <= '0;
      r_valid    <= 1'b0;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
      r_max_value <= '0;
`endif
    end else begin
      r_valid <= 1'b0;
      if (valid_in) begin
        r_max <= w_max_nxt;
        r_idx <= w_idx_nxt;
        // Last score of the group: publish the result including this sample.
        if (w_last) begin
          r_cnt      <= '0;
          r_decision <= w_idx_nxt;
          r_valid    <= 1'b1;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
          r_max_value <= w_max_nxt;
`endif
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign decision  = r_decision;
  assign valid_out = r_valid;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  assign max_value = r_max_value;
`endif

endmodule

// File: tb/tb_fc_argmax_comparator.sv
// Scoreboard bench for fc_argmax_comparator; expected decisions are queued with the cycle
// of the pulse they must appear on and checked one step after every clock edge.
module tb_fc_argmax_comparator;
  import cnn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  score_t     data_in;
  class_idx_t decision;
  logic       valid_out;
`ifdef ARGMAX_MAX_VALUE_OUT_EN
  score_t     max_value;
`endif

  fc_argmax_comparator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .decision  (decision),
    .valid_out (valid_out)
`ifdef ARGMAX_MAX_VALUE_OUT_EN
    ,
    .max_value (max_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int val;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   cyc      = 0;
  int   exp_hold = 0;

  function automatic int argmax(input int s[10]);
    int b = 0;
    for (int i = 1; i < 10; i++) if (s[i] > s[b]) b = i;
    return b;
  endfunction

  // One clock: drive inputs, take the edge, then check outputs 1ns later.
  task automatic step(input logic v, input int d);
    exp_t e;
    valid_in = v;
    data_in  = score_t'(d);
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      checks++;
      if (decision !== '0 || valid_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_state cyc=%0d decision=%0d valid_out=%b required decision=0 valid_out=0",
                 cyc, decision, valid_out);
      end
      exp_hold = 0;
    end else if (valid_out === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d valid_out=1 required 0", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc) begin
          errors++;
          $display("FAIL pulse_cycle got cyc=%0d required cyc=%0d", cyc, e.cyc);
        end
        checks++;
        if (int'(decision) !== e.idx) begin
          errors++;
          $display("FAIL decision got %0d required %0d", decision, e.idx);
        end
`ifdef ARGMAX_MAX_VALUE_OUT_EN
        checks++;
        if (int'(max_value) !== e.val) begin
          errors++;
          $display("FAIL max_value got %0d required %0d", max_value, e.val);
        end
`endif
        exp_hold = e.idx;
      end
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_pulse cyc=%0d valid_out=%b required 1", cyc, valid_out);
        void'(q.pop_front());
      end
      checks++;
      if (int'(decision) !== exp_hold) begin
        errors++;
        $display("FAIL decision_hold cyc=%0d got %0d required %0d", cyc, decision, exp_hold);
      end
    end
  endtask

  task automatic send_group(input int s[10], input int maxgap);
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      if (maxgap > 0 && i > 0)
        repeat ($urandom_range(1, maxgap)) step(1'b0, int'($urandom_range(0, 4095)) - 2048);
      if (i == 9) begin
        e.idx = argmax(s);
        e.val = s[e.idx];
        e.cyc = cyc + 1;
        q.push_back(e);
      end
      step(1'b1, s[i]);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) step(1'b0, 0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_outstanding pending=%0d required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(1'b1, 77);
    step(1'b1, 1500);
    rst_n = 1'b1;
    step(1'b0, 0);
    step(1'b0, 0);
  endtask

  task automatic test_basic();
    int s[10];
    s = '{5, -3, 100, 7, 0, 2, 99, -50, 1, 3};
    send_group(s, 0);
    drain("basic");
  endtask

  task automatic test_all_min();
    int s[10];
    foreach (s[i]) s[i] = -2048;
    send_group(s, 0);
    drain("all_min");
  endtask

  task automatic test_boundaries();
    int s[10];
    s = '{10, 20, 30, 40, -5, 0, 39, 1, 40, 2};
    send_group(s, 0);
    drain("tie");
    s = '{2046, -2048, 0, 2046, 1, 2045, -1, 100, 2046, 2047};
    send_group(s, 0);
    drain("last");
  endtask

  task automatic test_gaps();
    int s[10];
    s = '{5, -3, 100, 7, 0, 2, 99, -50, 1, 3};
    send_group(s, 3);
    drain("gaps");
  endtask

  task automatic test_back_to_back();
    int a[10];
    int b[10];
    a = '{1, 2, 300, 4, 5, 6, 7, 8, 9, 10};
    b = '{-10, -9, -8, -7, -6, -5, -4, 500, -2, -1};
    send_group(a, 0);
    send_group(b, 0);
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int s[10];
    step(1'b1, 900);
    step(1'b1, 901);
    step(1'b1, 902);
    step(1'b1, 903);
    rst_n = 1'b0;
    step(1'b1, 2000);
    rst_n = 1'b1;
    step(1'b0, 0);
    s = '{1, 2, 3, 4, 5, 6, 900, 7, 8, 9};
    send_group(s, 0);
    drain("reset_mid");
  endtask

  initial begin
    rst_n    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    test_reset();
    test_basic();
    test_all_min();
    test_boundaries();
    test_gaps();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
